aba_vec_accum: RTL and testbench
================================

// Module: aba_vec_accum
// PURPOSE
//  Parametrised multi-lane accumulate/bias/activation unit. It is the integer successor of the fixed
//  64-bit ABA path. It accumulates a group of signed input beats per lane and adds a per-lane bias.
//  It then rounds, shifts, applies the selected activation and saturates each lane to OUT_W.
//  Sits between the MAC array output stream and the writeback buffer.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  LANES   8   number of parallel lanes
//  DATA_W  8   signed input width per lane
//  ACC_W   24  signed accumulator and bias width per lane (ACC_W > DATA_W)
//  OUT_W   8   signed output width per lane
// PORTS
//  clk        in   1              system clock, single clock domain
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              input beat valid
//  in_ready   out  1              unit can accept a beat
//  in_data    in   LANES*DATA_W   lane i = in_data[i*DATA_W +: DATA_W], signed
//  in_last    in   1              beat is the last of its group
//  lane_en    in   LANES          per-lane load enable; disabled lanes add 0
//  bias       in   LANES*ACC_W    per-lane signed bias, sampled on first beat
//  act_mode   in   3              0 pass, 1 ReLU, 2 leaky ReLU (neg>>>3), 3 clamp [0,CLAMP], 4-7 = pass
//  shift      in   5              requant right shift, sampled on first beat
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts the result
//  out_data   out  LANES*OUT_W    per-lane signed result
//  overflow   out  LANES          per-lane saturation flag, qualified by out_valid
// BEHAVIOUR
//  Reset: state=ACC, first=1, in_ready=1 (combinational from state), out_valid=0, out_data=0,
//    overflow=0, all acc=0.
//  Reset mid-group discards the partial group.
//  Transfer: a beat or result moves when valid&&ready on the same clk edge.
//  FSM states:
//   ACC: in_ready=1. Each accepted beat updates acc_i:
//      - first beat: acc_i = bias_i + (lane_en[i] ? sext(x_i) : 0)
//      - later beats: acc_i += (lane_en[i] ? sext(x_i) : 0)
//      - add saturates at signed ACC_W limits and sets sticky ovf_i
//    On the first beat, also latch act_mode and shift, then clear first.
//    An accepted beat with in_last=1 moves to ACT.
//   ACT (1 cycle): in_ready=0. Per lane:
//      - r = (shift==0) ? acc : (acc + (1<<(shift-1))) >>> shift, computed at ACC_W+1 bits
//      - apply activation; CLAMP = 2^(OUT_W-1)-1 for mode 3
//      - saturate to signed OUT_W; ovf_i |= saturated
//    Register out_data and overflow=ovf, set out_valid=1, go to HOLD.
//   HOLD: in_ready=0. out_valid, out_data and overflow stay stable until out_ready.
//    On acceptance: out_valid=0, ovf=0, first=1, go to ACC.
//  Latency: last beat accepted on edge N gives out_valid=1 after edge N+1.
//    Minimum group-to-group spacing is 3 cycles.
//  Leaky ReLU uses an arithmetic (floor) shift: -20 gives -3.
//  Activation is applied after shift and before final saturation.
//  A single-beat group (in_last on the first beat) is legal.
//  in_valid is ignored while in_ready=0. Inputs need not be held.
// TESTING (LANES=8, DATA_W=8, ACC_W=24, OUT_W=8)
//  1. Reset and release: in_ready=1, out_valid=0, out_data=0, overflow=0.
//     Assert rst mid-HOLD: out_valid drops asynchronously.
//  2. Single beat, all lanes=5, bias=0, mode 0, shift 0, in_last=1:
//     every lane=8'h05 one cycle after acceptance, overflow=0.
//  3. Four beats of -10, bias=20 (acc=-20):
//     mode 1 gives 0, mode 2 gives -3 (8'hFD), mode 0 gives -20 (8'hEC).
//  4. Four beats of 127, bias=0:
//     shift 0 gives 127 with overflow=8'hFF; shift 2 gives 127 ((508+2)>>>2) with overflow=0.
//  5. lane_en=8'h0F, bias=3, two beats of 1, out_ready held low 10 cycles:
//     lanes 0-3=5, lanes 4-7=3. Outputs stay stable and in_ready=0 throughout the stall.
//  6. Two beats of 100, then rst pulse, then single beat 7 with bias 0:
//     result=7 in all lanes. No residue from the discarded group.

Source files
------------

// File: rtl/aba_vec_accum.sv
// Multi-lane accumulate / bias / requantise / activate unit with valid-ready on both sides.
// Each lane saturates in the accumulator and again at the output width; overflow is sticky per group.
module aba_vec_accum #(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  input  logic [LANES-1:0]        lane_en,
  input  logic [LANES*ACC_W-1:0]  bias,
  input  logic [2:0]              act_mode,
  input  logic [4:0]              shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  out_data,
  output logic [LANES-1:0]        overflow
);

  typedef enum logic [1:0] {S_ACC, S_ACT, S_HOLD} state_t;

  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));
  localparam logic signed [ACC_W:0] CLAMP   = OUT_MAX;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_first;
  logic [2:0]             r_mode;
  logic [4:0]             r_shift;
  logic [LANES*ACC_W-1:0] r_acc;
  logic [LANES*ACC_W-1:0] w_acc_next;
  logic [LANES-1:0]       r_ovf;
  logic [LANES-1:0]       w_add_ovf;
  logic [LANES-1:0]       w_res_ovf;
  logic [LANES*OUT_W-1:0] w_res;
  logic                   r_out_valid;
  logic [LANES*OUT_W-1:0] r_out_data;
  logic [LANES-1:0]       r_overflow;
  logic                   w_in_fire;
  logic                   w_out_fire;

  assign in_ready   = (r_state == S_ACC);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign overflow   = r_overflow;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0]     w_x;
    logic [ACC_W-1:0]      w_base_raw;
    logic [ACC_W-1:0]      w_acc_cur;
    logic signed [ACC_W:0] w_base;
    logic signed [ACC_W:0] w_addend;
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_acc_ext;
    logic signed [ACC_W:0] w_rnd;
    logic signed [ACC_W:0] w_rsum;
    logic signed [ACC_W:0] w_shr;
    logic signed [ACC_W:0] w_act;

    assign w_x        = in_data[g*DATA_W +: DATA_W];
    assign w_acc_cur  = r_acc[g*ACC_W +: ACC_W];
    assign w_base_raw = r_first ? bias[g*ACC_W +: ACC_W] : w_acc_cur;
    assign w_base     = {w_base_raw[ACC_W-1], w_base_raw};
    assign w_addend   = lane_en[g] ? {{(ACC_W+1-DATA_W){w_x[DATA_W-1]}}, w_x} : '0;
    assign w_sum      = w_base + w_addend;

    // One guard bit is enough to detect signed overflow of a single add.
    assign w_add_ovf[g] = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_next[g*ACC_W +: ACC_W] =
      !w_add_ovf[g] ? w_sum[ACC_W-1:0] :
      w_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                      {1'b0, {(ACC_W-1){1'b1}}};

    assign w_acc_ext = {w_acc_cur[ACC_W-1], w_acc_cur};
    assign w_rnd     = (r_shift == 5'd0) ? '0 :
                       ({{ACC_W{1'b0}}, 1'b1} << (r_shift - 5'd1));
    assign w_rsum    = w_acc_ext + w_rnd;
    assign w_shr     = w_rsum >>> r_shift;

    always_comb begin
      w_act = w_shr;
      case (r_mode)
        3'd1: if (w_shr[ACC_W]) w_act = '0;
        3'd2: if (w_shr[ACC_W]) w_act = w_shr >>> 3;
        3'd3: begin
          if (w_shr[ACC_W])       w_act = '0;
          else if (w_shr > CLAMP) w_act = CLAMP;
        end
        default: w_act = w_shr;
      endcase
    end

    assign w_res_ovf[g] = (w_act > OUT_MAX) || (w_act < OUT_MIN);
    assign w_res[g*OUT_W +: OUT_W] =
      (w_act > OUT_MAX) ? OUT_MAX[OUT_W-1:0] :
      (w_act < OUT_MIN) ? OUT_MIN[OUT_W-1:0] :
                          w_act[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACC:   if (w_in_fire && in_last) w_state_next = S_ACT;
      S_ACT:   w_state_next = S_HOLD;
      S_HOLD:  if (w_out_fire) w_state_next = S_ACC;
      default: w_state_next = S_ACC;
    endcase
  end

  // Mode and shift belong to the group, so they are captured only on its first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first     <= 1'b1;
      r_mode      <= '0;
      r_shift     <= '0;
      r_acc       <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= '0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_in_fire) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_add_ovf;
            if (r_first) begin
              r_mode  <= act_mode;
              r_shift <= shift;
              r_first <= 1'b0;
            end
          end
        end
        S_ACT: begin
          r_out_data  <= w_res;
          r_overflow  <= r_ovf | w_res_ovf;
          r_out_valid <= 1'b1;
        end
        S_HOLD: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_ovf       <= '0;
            r_first     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aba_vec_accum.sv
// Directed bench for aba_vec_accum: a lane model predicts each group result into a scoreboard
// queue as beats are driven, and results are popped and compared when the unit presents them.
module tb_aba_vec_accum;

  localparam int LANES  = 8;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_last;
  logic [7:0]   lane_en;
  logic [191:0] bias;
  logic [2:0]   act_mode;
  logic [4:0]   shift;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [7:0]   overflow;

  exp_t       sbQueue[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         mAcc[8];
  logic [7:0] mOvf;
  bit         mFirst;
  int         mMode;
  int         mShift;

  always #5 clk = ~clk;

  aba_vec_accum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .lane_en(lane_en), .bias(bias), .act_mode(act_mode), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mFirst = 1'b1;
    mOvf   = '0;
    for (int l = 0; l < 8; l++) mAcc[l] = 0;
    sbQueue.delete();
  endtask

  task automatic pushResult();
    exp_t   e;
    longint r;
    e = '0;
    for (int l = 0; l < 8; l++) begin
      r = mAcc[l];
      if (mShift != 0) r = (r + (longint'(1) <<< (mShift - 1))) >>> mShift;
      case (mMode)
        1: if (r < 0) r = 0;
        2: if (r < 0) r = r >>> 3;
        3: begin
          if (r < 0) r = 0;
          else if (r > 127) r = 127;
        end
        default: ;
      endcase
      if (r > 127) begin
        r = 127; mOvf[l] = 1'b1;
      end else if (r < -128) begin
        r = -128; mOvf[l] = 1'b1;
      end
      e.data[l*8 +: 8] = 8'(r);
      e.ovf[l] = mOvf[l];
    end
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] x, input bit last, input logic [7:0] en,
                               input int b, input int mode, input int sh);
    int n;
    int s;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    in_data  = {8{x}};
    bias     = {8{24'(b)}};
    act_mode = 3'(mode);
    shift    = 5'(sh);
    in_last  = last;
    lane_en  = en;
    in_valid = 1'b1;
    if (mFirst) begin
      mMode  = mode;
      mShift = sh;
    end
    for (int l = 0; l < 8; l++) begin
      s = (mFirst ? b : mAcc[l]) + (en[l] ? int'($signed(x)) : 0);
      if (s > 8388607) begin
        s = 8388607; mOvf[l] = 1'b1;
      end else if (s < -8388608) begin
        s = -8388608; mOvf[l] = 1'b1;
      end
      mAcc[l] = s;
    end
    mFirst = 1'b0;
    if (last) pushResult();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = {$urandom, $urandom};
    bias     = {6{$urandom}};
    act_mode = 3'($urandom);
    shift    = 5'($urandom);
  endtask

  task automatic checkOutput(input string tag, input int stall);
    exp_t e;
    int   n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    if (sbQueue.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = sbQueue.pop_front();
    check({tag, "_data"}, out_data, e.data);
    check({tag, "_ovf"}, {56'd0, overflow}, {56'd0, e.ovf});
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_stall_data"}, out_data, e.data);
      check({tag, "_stall_ovf"}, {56'd0, overflow}, {56'd0, e.ovf});
      check({tag, "_stall_ready"}, {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    mOvf   = '0;
    mFirst = 1'b1;
    check({tag, "_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_rdy_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; lane_en = '0;
    bias = '0; act_mode = '0; shift = '0; out_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_overflow", {56'd0, overflow}, 64'd0);

    // Reset while holding a result must drop out_valid without a clock edge.
    applyStimulus(8'd9, 1'b1, 8'hFF, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("hold_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    applyStimulus(8'd5, 1'b1, 8'hFF, 0, 0, 0);
    check("lat_act_valid", {63'd0, out_valid}, 64'd0);
    check("lat_act_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("lat_valid", {63'd0, out_valid}, 64'd1);
    check("single_const", out_data, {8{8'h05}});
    checkOutput("single", 0);

    for (int m = 0; m < 3; m++) begin
      for (int b = 0; b < 4; b++) applyStimulus(8'hF6, b == 3, 8'hFF, 20, (m == 2) ? 0 : m + 1, 0);
      if (m == 1) begin
        @(negedge clk);
        check("leaky_const", out_data, {8{8'hFD}});
      end
      checkOutput("neg_group", 0);
    end

    for (int b = 0; b < 4; b++) applyStimulus(8'd127, b == 3, 8'hFF, 0, 0, 0);
    @(negedge clk);
    check("sat_ovf_const", {56'd0, overflow}, 64'hFF);
    checkOutput("sat_shift0", 0);
    for (int b = 0; b < 4; b++) applyStimulus(8'd127, b == 3, 8'hFF, 0, 0, 2);
    checkOutput("round_shift2", 0);

    applyStimulus(8'd1, 1'b0, 8'h0F, 3, 0, 0);
    applyStimulus(8'd1, 1'b1, 8'h0F, 3, 0, 0);
    @(negedge clk);
    check("lane_en_const", out_data, {{4{8'h03}}, {4{8'h05}}});
    checkOutput("stall", 10);

    applyStimulus(8'd10, 1'b1, 8'hFF, 200, 3, 0);
    checkOutput("clamp", 0);
    applyStimulus(8'd0, 1'b1, 8'hFF, -1000, 0, 0);
    checkOutput("neg_sat", 0);
    applyStimulus(8'd127, 1'b1, 8'hFF, 8388600, 0, 20);
    checkOutput("acc_sticky", 0);
    applyStimulus(8'hEC, 1'b1, 8'hA5, 0, 2, 0);
    checkOutput("leaky_mixed", 0);

    applyStimulus(8'd100, 1'b0, 8'hFF, 0, 0, 0);
    applyStimulus(8'd100, 1'b0, 8'hFF, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(8'd7, 1'b1, 8'hFF, 0, 0, 0);
    @(negedge clk);
    check("no_residue_const", out_data, {8{8'h07}});
    checkOutput("after_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
